// File: rtl/furv_pkg.sv
// Shared types for the furv core memory subsystem.
// Arbiter FSM states and grant owners live here.
package furv_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the unified single-port RAM.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_arbiter
  import furv_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  arb_state_t        state_nx;
  arb_owner_t        owner;
  arb_owner_t        owner_nx;
  logic              owner_we;
  logic              owner_we_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;

  logic is_idle;
  logic starved;
  logic grant_d;
  logic grant_if;
  logic resp_d;
  logic resp_if;

  assign is_idle  = (state == ARB_IDLE);
  assign starved  = if_req && (wait_cnt == WAIT_TOP);
  assign grant_d  = is_idle && d_req && !starved;
  assign grant_if = is_idle && if_req && !grant_d;
  assign resp_d   = (state == ARB_RESP) && (owner == OWN_D);
  assign resp_if  = (state == ARB_RESP) && (owner == OWN_IF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= OWN_IF;
      owner_we <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      owner_we <= owner_we_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    owner_we_nx = owner_we;
    wait_nx     = wait_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (grant_d) begin
          state_nx    = ARB_RESP;
          owner_nx    = OWN_D;
          owner_we_nx = d_we;
        end else if (grant_if) begin
          state_nx    = ARB_RESP;
          owner_nx    = OWN_IF;
          owner_we_nx = 1'b0;
        end
      end
      ARB_RESP: state_nx = ARB_IDLE;
      default:  state_nx = ARB_IDLE;
    endcase
    // Counts data wins that fetch lost; any idle fetch cycle clears it.
    if (!if_req) begin
      wait_nx = '0;
    end else if (grant_if) begin
      wait_nx = '0;
    end else if (grant_d && (wait_cnt != WAIT_TOP)) begin
      wait_nx = wait_cnt + 1'b1;
    end
  end

  always_comb begin
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    if_ack   = 1'b0;
    if_rdata = '0;
    d_ack    = 1'b0;
    d_rdata  = '0;
    if (rst_n) begin
      unique case (1'b1)
        grant_d: begin
          m_en   = 1'b1;
          m_we   = d_we;
          m_addr = d_addr;
          if (d_we) m_wdata = d_wdata;
        end
        grant_if: begin
          m_en   = 1'b1;
          m_addr = if_addr;
        end
        resp_d: begin
          d_ack = 1'b1;
          if (!owner_we) d_rdata = m_rdata;
        end
        resp_if: begin
          if_ack = 1'b1;
          if (!owner_we) if_rdata = m_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM.
// Stimulus queues expected grants/acks; a negedge monitor checks them.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     vectors = 0;
  int     errs    = 0;
  int     gidx    = 0;
  int     aidx    = 0;

  logic [31:0] mem [0:511];

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_ack  (if_ack),
    .if_rdata(if_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[10:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[10:2]];
    end
  end

  task automatic push_grant(input logic we, input logic [31:0] a,
                            input logic [31:0] wd);
    grant_t g;
    g.we = we;
    g.addr = a;
    g.wdata = wd;
    gq.push_back(g);
  endtask

  task automatic push_ack(input logic is_d, input logic [31:0] rd);
    ack_t k;
    k.is_d = is_d;
    k.rdata = rd;
    aq.push_back(k);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      vectors++;
      if (m_en || m_we || m_addr != 0 || m_wdata != 0 || if_ack ||
          d_ack || if_rdata != 0 || d_rdata != 0) begin
        errs++;
        $display("FAIL reset_out: got en=%0b we=%0b addr=%h wd=%h ia=%0b da=%0b ir=%h dr=%h, want all 0",
                 m_en, m_we, m_addr, m_wdata, if_ack, d_ack, if_rdata, d_rdata);
      end
    end else begin
      vectors++;
      if (m_en) begin
        if (gq.size() == 0) begin
          errs++;
          $display("FAIL grant_extra: got addr=%h we=%0b, want no strobe",
                   m_addr, m_we);
        end else begin
          grant_t g;
          g = gq.pop_front();
          if (m_we !== g.we || m_addr !== g.addr || m_wdata !== g.wdata) begin
            errs++;
            $display("FAIL grant%0d: got we=%0b addr=%h wd=%h, want we=%0b addr=%h wd=%h",
                     gidx, m_we, m_addr, m_wdata, g.we, g.addr, g.wdata);
          end
          gidx++;
        end
      end else if (m_we || m_addr != 0 || m_wdata != 0) begin
        errs++;
        $display("FAIL idle_bus: got we=%0b addr=%h wd=%h, want 0",
                 m_we, m_addr, m_wdata);
      end
      if (if_ack || d_ack) begin
        vectors++;
        if (aq.size() == 0) begin
          errs++;
          $display("FAIL ack_extra: got ia=%0b da=%0b, want none",
                   if_ack, d_ack);
        end else begin
          ack_t k;
          logic [31:0] exp_ir;
          logic [31:0] exp_dr;
          k = aq.pop_front();
          exp_ir = k.is_d ? 32'h0 : k.rdata;
          exp_dr = k.is_d ? k.rdata : 32'h0;
          if (if_ack !== !k.is_d || d_ack !== k.is_d ||
              if_rdata !== exp_ir || d_rdata !== exp_dr) begin
            errs++;
            $display("FAIL ack%0d: got ia=%0b da=%0b ir=%h dr=%h, want ia=%0b da=%0b ir=%h dr=%h",
                     aidx, if_ack, d_ack, if_rdata, d_rdata,
                     !k.is_d, k.is_d, exp_ir, exp_dr);
          end
          aidx++;
        end
      end else if (if_rdata != 0 || d_rdata != 0) begin
        errs++;
        $display("FAIL rdata_idle: got ir=%h dr=%h, want 0",
                 if_rdata, d_rdata);
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h020] = 32'hA5A5_0001;
    mem[9'h080] = 32'h0000_2000;
    mem[9'h040] = 32'hDEAD_BEEF;
    mem[9'h0C0] = 32'hC0C0_C0C0;
    mem[9'h100] = 32'h0400_F00D;
    m_rdata = 32'h0;

    // Reset with both requesters asserted.
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h80;
    d_wdata = 32'h0;
    cyc(3);
    push_grant(1'b0, 32'h80, 32'h0);
    push_ack(1'b1, 32'hA5A5_0001);
    push_grant(1'b0, 32'h200, 32'h0);
    push_ack(1'b0, 32'h0000_2000);
    rst_n = 1'b1;
    cyc(2);
    d_req = 1'b0;
    cyc(2);
    if_req = 1'b0;
    cyc(2);

    // Lone fetch.
    push_grant(1'b0, 32'h100, 32'h0);
    push_ack(1'b0, 32'hDEAD_BEEF);
    if_addr = 32'h100;
    if_req  = 1'b1;
    cyc(2);
    if_req = 1'b0;
    cyc(2);

    // Store then load to 0x40.
    push_grant(1'b1, 32'h40, 32'h1234);
    push_ack(1'b1, 32'h0);
    push_grant(1'b0, 32'h40, 32'h0);
    push_ack(1'b1, 32'h1234);
    d_addr  = 32'h40;
    d_wdata = 32'h1234;
    d_we    = 1'b1;
    d_req   = 1'b1;
    cyc(2);
    d_we    = 1'b0;
    d_wdata = 32'h0;
    cyc(2);
    d_req = 1'b0;
    cyc(2);

    // Starvation: D,D,D,D,IF,D.
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        push_grant(1'b0, 32'h400, 32'h0);
        push_ack(1'b0, 32'h0400_F00D);
      end else begin
        push_grant(1'b0, 32'h300, 32'h0);
        push_ack(1'b1, 32'hC0C0_C0C0);
      end
    end
    d_addr  = 32'h300;
    if_addr = 32'h400;
    d_req   = 1'b1;
    if_req  = 1'b1;
    cyc(12);
    d_req  = 1'b0;
    if_req = 1'b0;
    cyc(2);

    // Fetch drops at wait_cnt=3: D x8, IF, D.
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        push_grant(1'b0, 32'h400, 32'h0);
        push_ack(1'b0, 32'h0400_F00D);
      end else begin
        push_grant(1'b0, 32'h300, 32'h0);
        push_ack(1'b1, 32'hC0C0_C0C0);
      end
    end
    d_req  = 1'b1;
    if_req = 1'b1;
    cyc(5);
    if_req = 1'b0;
    cyc(2);
    if_req = 1'b1;
    cyc(13);
    d_req  = 1'b0;
    if_req = 1'b0;
    cyc(2);

    // Reset during the response of a load.
    push_grant(1'b0, 32'h40, 32'h0);
    d_addr = 32'h40;
    d_req  = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    d_req = 1'b0;
    cyc(1);
    push_grant(1'b0, 32'h40, 32'h0);
    push_ack(1'b1, 32'h1234);
    push_grant(1'b0, 32'h100, 32'h0);
    push_ack(1'b0, 32'hDEAD_BEEF);
    rst_n   = 1'b1;
    if_addr = 32'h100;
    if_req  = 1'b1;
    d_req   = 1'b1;
    cyc(2);
    d_req = 1'b0;
    cyc(2);
    if_req = 1'b0;
    cyc(3);

    vectors++;
    if (gq.size() != 0) begin
      errs++;
      $display("FAIL grant_drain: got %0d pending, want 0", gq.size());
    end
    vectors++;
    if (aq.size() != 0) begin
      errs++;
      $display("FAIL ack_drain: got %0d pending, want 0", aq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port synchronous memory between the core's instruction-fetch port and its load/store data port. Sits between a stall-capable `furv`-family core and the unified program/data RAM. Data accesses have fixed priority, with a starvation guard that forces a fetch grant after `MAX_WAIT` consecutive losses. One transaction in flight at a time: a two-cycle issue/response sequence per access.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MAX_WAIT`, 4, consecutive lost arbitrations after which fetch wins (≥1)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_ack`  out  1  one-cycle fetch completion
- `if_rdata`  out  DATA_W  fetched word, valid only with `if_ack`, else 0
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle data completion
- `d_rdata`  out  DATA_W  load word, valid only with `d_ack` on a load, else 0
- `m_en`  out  1  memory access strobe
- `m_we`  out  1  memory write enable, 0 unless `m_en`
- `m_addr`  out  ADDR_W  memory address, 0 unless `m_en`
- `m_wdata`  out  DATA_W  memory write data, 0 unless `m_en && m_we`
- `m_rdata`  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- States: `IDLE`, `RESP`. Registers: `state`, `owner` (IF/D), `owner_we`, `wait_cnt` (width `$clog2(MAX_WAIT+1)`).
- `IDLE`, no request: all `m_*` = 0, stay.
- `IDLE`, request(s) pending: grant selection:
  - `d_req && !(if_req && wait_cnt == MAX_WAIT)` → D;
  - else if `if_req` → IF.
- On grant (same cycle, combinational): `m_en`=1, `m_addr` = granted address.
  - D store: `m_we`=1, `m_wdata`=`d_wdata`.
  - Fetch is always a read.
  - Latch `owner`/`owner_we`; go to `RESP`.
- `wait_cnt` (updated on `IDLE` grant cycles only):
  - D granted while `if_req` → `wait_cnt+1`, saturating at `MAX_WAIT`.
  - IF granted → 0.
  - `!if_req` in any cycle → 0.
- `RESP`:
  - `m_*` = 0.
  - Owner's ack = 1.
  - Owner's rdata = `m_rdata` if a read, else 0.
  - Other port: ack 0, rdata 0.
  - Always return to `IDLE`.
- Requests arriving during `RESP` are not sampled; they are arbitrated in the following `IDLE` cycle.
- A requester must deassert or present a new request in the cycle after its ack. Behaviour for a changed address/data while `req` is held is undefined.

## Timing
- Latency: request seen in `IDLE` at cycle N → memory strobe at N → ack at N+1.
- Throughput: one access per 2 cycles. Back-to-back requests issue at N, N+2, N+4, …
- Simultaneous `if_req`/`d_req` with `wait_cnt < MAX_WAIT`: D at N, IF at N+2 (if still requesting).
- Continuous `d_req` + `if_req`, `MAX_WAIT`=4: grants D,D,D,D,IF,D,D,D,D,IF,…
- Reset (`rst_n`=0 at a rising edge): `state`=`IDLE`, `owner`=IF, `owner_we`=0, `wait_cnt`=0.
  - While `rst_n`=0, every output is forced to 0, including combinational `m_*`.
- Reset asserted in `RESP`: pending ack is dropped. A store already strobed may have committed; the requester must re-issue after reset.
- No combinational path from `m_rdata` to any `m_*` output.

## Structure
- Shared package `furv_pkg`: `arb_state_t` (`ARB_IDLE`, `ARB_RESP`), `arb_owner_t` (`OWN_IF`, `OWN_D`).
- Single module. No sub-module is warranted; the starvation counter stays inline.

## Test plan
- Reset: hold `rst_n`=0 with both `req`=1 → all outputs 0. Release → D granted first, `m_addr`=`d_addr`.
- Lone fetch: `if_req`, `if_addr`=0x100, memory returns 0xDEADBEEF → `m_en`@N, `if_ack`@N+1 with `if_rdata`=0xDEADBEEF, `d_ack`=0 throughout.
- Store then load to 0x40: store `d_wdata`=0x1234 → `m_we`=1, `d_rdata`=0 at ack. Load → `d_rdata`=0x1234 at ack.
- Starvation: both `req` held 12 cycles, `MAX_WAIT`=4 → grant sequence D,D,D,D,IF,D; `wait_cnt` returns to 0 after the IF grant.
- `if_req` dropped mid-wait at `wait_cnt`=3 → counter clears. Next contention gives D four more grants before IF.
- Reset in `RESP` of a load → no ack that cycle. Next `IDLE` arbitration starts clean.
